// File: rtl/aes_pkg.sv
// Shared Rijndael helpers: row shift offsets, byte indexing within a
// column-major state, and the legal block-width check.
package aes_pkg;

  localparam int ROWS = 4;

  // NB=8 moves rows 2 and 3 one column further than the 128/192-bit blocks do.
  function automatic int shift_off(input int nb, input int r);
    if (nb == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

endpackage

// File: rtl/aes_shiftrows_nb.sv
// Combinational Rijndael ShiftRows / InvShiftRows for NB columns.
// Pure wiring plus one 2:1 byte mux per byte selected by i_inv.
module aes_shiftrows_nb
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] i_state,
  input  logic             i_inv,
  output logic [32*NB-1:0] o_state
);

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < NB; gj++) begin : g_col
      localparam int OFF   = shift_off(NB, gi);
      localparam int SRC_F = (gj + OFF) % NB;
      localparam int SRC_I = (gj - OFF + NB) % NB;
      localparam int DST   = byte_idx(gi, gj);
      localparam int BF    = byte_idx(gi, SRC_F);
      localparam int BI    = byte_idx(gi, SRC_I);

      assign o_state[8*DST +: 8] = i_inv ? i_state[8*BI +: 8] : i_state[8*BF +: 8];
    end
  end

endmodule

// File: rtl/aes_shiftrows_stage.sv
// Registered ShiftRows/InvShiftRows stage: transform on the write path into
// a small FIFO so the round pipeline can absorb downstream stalls.
module aes_shiftrows_stage
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [32*NB-1:0]           in_data,
  input  logic                       in_inv,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [32*NB-1:0]           out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int W     = 32 * NB;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  if (!nb_legal(NB)) begin : g_err_nb
    $error("aes_shiftrows_stage: NB must be 4, 6 or 8");
  end
  if (DEPTH < 1 || DEPTH > 4) begin : g_err_depth
    $error("aes_shiftrows_stage: DEPTH must be in 1..4");
  end
  if (TAG_W < 1) begin : g_err_tag
    $error("aes_shiftrows_stage: TAG_W must be at least 1");
  end

  logic [W-1:0]     r_mem_data [DEPTH];
  logic [TAG_W-1:0] r_mem_tag  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic [W-1:0]     w_xform;
  logic             w_accept;
  logic             w_emit;

  aes_shiftrows_nb #(
    .NB (NB)
  ) u_shiftrows (
    .i_state (in_data),
    .i_inv   (in_inv),
    .o_state (w_xform)
  );

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (r_level < LVL_FULL);
  assign out_valid = (r_level != '0);
  assign out_data  = r_mem_data[r_rd_ptr];
  assign out_tag   = r_mem_tag[r_rd_ptr];
  assign level     = r_level;

  assign w_accept  = in_valid && in_ready && !flush;
  assign w_emit    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_tag[i]  <= '0;
      end
    end else if (w_accept) begin
      r_mem_data[r_wr_ptr] <= w_xform;
      r_mem_tag[r_wr_ptr]  <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_emit) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_accept && !w_emit) begin
        r_level <= r_level + LVL_W'(1);
      end else if (!w_accept && w_emit) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes_shiftrows_stage.sv
// Directed-vector bench for aes_shiftrows_stage at NB=4/6/8 plus
// back-pressure, concurrent accept/emit, flush and async reset sequences.
module tb_aes_shiftrows_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // NB=4 instance
  logic         flush4 = 1'b0, in_valid4 = 1'b0, in_inv4 = 1'b0, out_ready4 = 1'b1;
  logic         in_ready4, out_valid4;
  logic [127:0] in_data4 = '0, out_data4;
  logic [3:0]   in_tag4 = '0, out_tag4;
  logic [1:0]   level4;

  // NB=6 instance
  logic         in_valid6 = 1'b0, in_inv6 = 1'b0;
  logic         in_ready6, out_valid6;
  logic [191:0] in_data6 = '0, out_data6;
  logic [3:0]   out_tag6;
  logic [1:0]   level6;

  // NB=8 instance
  logic         in_valid8 = 1'b0, in_inv8 = 1'b0;
  logic         in_ready8, out_valid8;
  logic [255:0] in_data8 = '0, out_data8;
  logic [3:0]   out_tag8;
  logic [1:0]   level8;

  aes_shiftrows_stage #(.NB(4), .DEPTH(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .in_inv(in_inv4), .in_tag(in_tag4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_tag(out_tag4), .level(level4)
  );

  aes_shiftrows_stage #(.NB(6), .DEPTH(2), .TAG_W(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
    .in_inv(in_inv6), .in_tag(4'h6),
    .out_valid(out_valid6), .out_ready(1'b1), .out_data(out_data6),
    .out_tag(out_tag6), .level(level6)
  );

  aes_shiftrows_stage #(.NB(8), .DEPTH(2), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .in_inv(in_inv8), .in_tag(4'h8),
    .out_valid(out_valid8), .out_ready(1'b1), .out_data(out_data8),
    .out_tag(out_tag8), .level(level8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0] data;
    logic         inv;
    logic [3:0]   tag;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] FIPS_IN  = 128'h3052411ee55db4b8f198bfe0ae1127d4;
  localparam logic [127:0] FIPS_OUT = 128'he598271ef11141b8ae52b4e0305dbfd4;
  localparam logic [127:0] SEQ16    = 128'h0f0e0d0c0b0a09080706050403020100;

  vec_t vecs [5];

  // Byte i = i, built once for the wide instances.
  function automatic logic [255:0] seq_bytes(input int n);
    logic [255:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = 8'(i);
    return v;
  endfunction

  initial begin
    logic [255:0] seq;
    logic [3:0]   exp_tag;

    vecs[0] = '{FIPS_IN,  1'b0, 4'h1, FIPS_OUT};
    vecs[1] = '{FIPS_OUT, 1'b1, 4'hA, FIPS_IN};
    vecs[2] = '{SEQ16,    1'b0, 4'h3, 128'h0b06010c07020d08030e09040f0a0500};
    vecs[3] = '{SEQ16,    1'b1, 4'h5, 128'h0306090c0f0205080b0e0104070a0d00};
    vecs[4] = '{128'h0,   1'b1, 4'hF, 128'h0};

    // Reset state
    #12;
    chk("rst_out_valid", out_valid4, 0);
    chk("rst_in_ready",  in_ready4, 1);
    chk("rst_level",     level4, 0);
    chk("rst_out_data",  out_data4, 0);
    chk("rst_out_tag",   out_tag4, 0);
    @(negedge clk) rst_n = 1'b1;

    // Table-driven NB=4 vectors, one beat at a time
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      in_valid4 = 1'b1; in_data4 = vecs[v].data; in_inv4 = vecs[v].inv; in_tag4 = vecs[v].tag;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", v), out_valid4, 1);
      chk($sformatf("vec%0d_data", v),  out_data4, vecs[v].exp);
      chk($sformatf("vec%0d_tag", v),   out_tag4, vecs[v].tag);
      $display("vec %0d inv=%0d tag=%0h out=%032h", v, vecs[v].inv, vecs[v].tag, out_data4);
      @(negedge clk) in_valid4 = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_drain", v), level4, 0);
    end

    // NB=6 and NB=8 forward/inverse on byte-index patterns
    seq = seq_bytes(32);
    @(negedge clk);
    in_valid6 = 1'b1; in_data6 = seq[191:0]; in_inv6 = 1'b0;
    in_valid8 = 1'b1; in_data8 = seq;        in_inv8 = 1'b0;
    @(posedge clk); #1;
    chk("nb6_fwd_col0", out_data6[31:0],    32'h0f0a0500);
    chk("nb6_fwd_col5", out_data6[191:160], 32'h0b060114);
    chk("nb6_tag",      out_tag6, 4'h6);
    chk("nb8_fwd_col0", out_data8[31:0],    32'h130e0500);
    chk("nb8_fwd_col7", out_data8[255:224], 32'h0f0a011c);
    chk("nb8_tag",      out_tag8, 4'h8);
    $display("nb6 fwd out=%048h", out_data6);
    $display("nb8 fwd out=%064h", out_data8);
    @(negedge clk);
    in_valid6 = 1'b0; in_inv8 = 1'b1;
    @(posedge clk); #1;
    chk("nb8_inv_col0", out_data8[31:0], 32'h13161d00);
    $display("nb8 inv out=%064h", out_data8);
    @(negedge clk) in_valid8 = 1'b0;
    @(posedge clk); #1;
    chk("nb8_drain", level8, 0);

    // Back-pressure: three pushes into DEPTH=2 with out_ready low
    @(negedge clk);
    out_ready4 = 1'b0; in_valid4 = 1'b1; in_inv4 = 1'b0;
    in_data4 = {16{8'h11}}; in_tag4 = 4'h1;
    @(posedge clk); #1;
    chk("bp_level1", level4, 1);
    chk("bp_ready1", in_ready4, 1);
    @(negedge clk) begin in_data4 = {16{8'h22}}; in_tag4 = 4'h2; end
    @(posedge clk); #1;
    chk("bp_level2", level4, 2);
    chk("bp_full_ready", in_ready4, 0);
    @(negedge clk) begin in_data4 = {16{8'h33}}; in_tag4 = 4'h3; end
    @(posedge clk); #1;
    chk("bp_hold_level", level4, 2);
    chk("bp_hold_data", out_data4, {16{8'h11}});
    chk("bp_hold_tag", out_tag4, 4'h1);
    $display("bp: stalled with level=%0d head tag=%0h", level4, out_tag4);
    @(negedge clk) begin in_valid4 = 1'b0; out_ready4 = 1'b1; end
    @(posedge clk); #1;
    chk("bp_emit1_tag", out_tag4, 4'h2);
    chk("bp_emit1_data", out_data4, {16{8'h22}});
    chk("bp_emit1_level", level4, 1);
    @(posedge clk); #1;
    chk("bp_emit2_valid", out_valid4, 0);

    // Concurrent accept and emit at level 1 for 8 cycles
    @(negedge clk) begin in_valid4 = 1'b1; in_data4 = SEQ16; in_inv4 = 1'b0; in_tag4 = 4'h0; end
    @(posedge clk); #1;
    chk("ae_prime_level", level4, 1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk) in_tag4 = 4'(i);
      @(posedge clk); #1;
      exp_tag = 4'(i);
      chk($sformatf("ae%0d_level", i), level4, 1);
      chk($sformatf("ae%0d_ready", i), in_ready4, 1);
      chk($sformatf("ae%0d_tag", i), out_tag4, exp_tag);
      $display("ae cycle %0d head tag=%0h level=%0d", i, out_tag4, level4);
    end

    // Flush together with in_valid: the concurrent beat must vanish
    @(negedge clk) begin flush4 = 1'b1; in_tag4 = 4'h9; end
    @(posedge clk); #1;
    chk("flush_level", level4, 0);
    chk("flush_valid", out_valid4, 0);
    @(negedge clk) begin flush4 = 1'b0; in_valid4 = 1'b0; end
    @(posedge clk); #1;
    chk("flush_absent", out_valid4, 0);
    @(negedge clk) begin in_valid4 = 1'b1; in_data4 = FIPS_IN; in_tag4 = 4'hC; end
    @(posedge clk); #1;
    chk("post_flush_tag", out_tag4, 4'hC);
    chk("post_flush_data", out_data4, FIPS_OUT);
    @(negedge clk) in_valid4 = 1'b0;
    @(posedge clk); #1;

    // Async reset mid-burst with two beats buffered
    @(negedge clk) begin out_ready4 = 1'b0; in_valid4 = 1'b1; in_data4 = SEQ16; in_tag4 = 4'h4; end
    @(posedge clk);
    @(negedge clk) in_tag4 = 4'h7;
    @(posedge clk); #1;
    chk("pre_rst_level", level4, 2);
    #2;
    in_valid4 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid4, 0);
    chk("arst_ready", in_ready4, 1);
    chk("arst_level", level4, 0);
    chk("arst_data", out_data4, 0);
    $display("async reset: level=%0d in_ready=%0d", level4, in_ready4);
    @(negedge clk) begin rst_n = 1'b1; out_ready4 = 1'b1; end
    @(negedge clk) begin in_valid4 = 1'b1; in_data4 = FIPS_IN; in_inv4 = 1'b0; in_tag4 = 4'hE; end
    @(posedge clk); #1;
    chk("after_rst_data", out_data4, FIPS_OUT);
    chk("after_rst_tag", out_tag4, 4'hE);
    chk("after_rst_level", level4, 1);
    @(negedge clk) in_valid4 = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_drain", out_valid4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_shiftrows_stage.md
# aes_shiftrows_stage

Registered, parametrised Rijndael ShiftRows/InvShiftRows stage with valid/ready flow control and a small output buffer. It generalises the combinational AES ShiftRows to Rijndael block widths of 128/192/256 bits (NB = 4/6/8 columns) and adds per-beat forward/inverse mode and a sideband tag. It sits between the SubBytes and MixColumns stages of the pipelined round datapath and lets the round pipeline absorb downstream stalls.

## Interface
- NB, 4, state columns; legal values 4, 6, 8; state width is 32*NB bits
- DEPTH, 2, output buffer entries; legal values 1..4
- TAG_W, 4, sideband tag width; must be at least 1
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- flush  in  1  synchronous clear of buffered beats
- in_valid  in  1  input beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_data  in  32*NB  state, column-major: byte (r,c) = bits [8*(4c+r)+7 : 8*(4c+r)]
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows (per beat)
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts
- out_data  out  32*NB  transformed state
- out_tag  out  TAG_W  tag of the current output beat
- level  out  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Row offsets: NB=4 or 6 → {0,1,2,3}; NB=8 → {0,1,3,4}.
- Forward: out(r,c) = in(r, (c+off_r) mod NB). Inverse: out(r,c) = in(r, (c−off_r) mod NB). Row 0 is never moved.
- Transform is applied on the write path. The buffer stores transformed data and the tag.
- The buffer is a DEPTH-entry FIFO with write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- in_ready = (level < DEPTH). It is registered-state-only: no combinational path from out_ready.
- out_valid = (level != 0). out_data and out_tag are driven from the head entry.
- Simultaneous accept and emit: level is unchanged and both pointers advance.
- Emit while full: in_ready is 0 in that cycle. The freed slot is visible the next cycle.
- Emit while empty: impossible, because out_valid is 0.
- flush: level ← 0 and pointers ← 0 on the next edge. Any accept in the same cycle is discarded, and in_valid is ignored. out_valid is 0 from the following cycle.
- Out-of-range parameters trigger an elaboration-time $error.

## Timing
- Reset (rst_n low, async): level=0, pointers=0, out_valid=0, in_ready=1. out_data and out_tag read as 0, and buffer storage is cleared.
- Reset mid-operation drops all buffered beats. No partial beat ever emerges.
- Latency: a beat accepted at edge k is visible on out_valid/out_data after edge k, i.e. in cycle k+1.
- Throughput: one beat/cycle sustained when DEPTH ≥ 2 and out_ready is held 1. DEPTH=1 gives one beat every 2 cycles under back-pressure-free operation.
- out_data and out_tag must hold stable while out_valid=1 and out_ready=0.
- Ordering is strictly FIFO. Mode and tag stay attached to their own beat.

## Structure
- Shared package aes_pkg holds:
  - the row-offset function shift_off(nb, r);
  - the byte-index function byte_idx(r, c) = 4c+r;
  - the legal-NB check.
- One combinational sub-module, aes_shiftrows_nb (parameter NB, inputs state/inv, output state), is instantiated on the write path. The existing fixed ShiftRows is equivalent to aes_shiftrows_nb with NB=4, inv=0.
- The FIFO stays in this module. No separate memory module is needed.

## Test plan
- FIPS-197 forward, NB=4, in_inv=0, in_data=0x3052411ee55db4b8f198bfe0ae1127d4 → out_data=0xe598271ef11141b8ae52b4e0305dbfd4 one cycle after accept.
- Inverse round-trip: feed the previous output with in_inv=1 and tag=0xA → out_data=0x3052411ee55db4b8f198bfe0ae1127d4, out_tag=0xA.
- NB=8 forward, in byte i = i for i = 0..31 → out bytes 0..3 = 0x00,0x05,0x0e,0x13. NB=6, same pattern → out bytes 0..3 = 0x00,0x05,0x0a,0x0f.
- Back-pressure, DEPTH=2: hold out_ready=0 and push 3 beats → in_ready=0 after 2 accepts, level=2. Release out_ready → beats emerge in order, one per cycle.
- Simultaneous accept and emit at level=1 for 8 cycles → level stays 1 and in_ready stays 1. Then assert flush together with in_valid → level=0 and out_valid=0 next cycle, with the flushed beat absent.
- Assert rst_n low asynchronously mid-burst with level=2 → out_valid=0 and in_ready=1 immediately. After release the first new beat is output correctly.
